// File: rtl/lanectrl_pause_sync_mc_if.sv
// Pause-request bundle between DDR training/PHY control (master) and the
// lane pause synchroniser (slave). Clock and reset stay outside the bundle.
interface lanectrl_pause_sync_mc_if #(
   parameter int NUM_LANES = 4
) ();
   logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE;
   logic [NUM_LANES-1:0] LANE_EN;
   logic                 CLR_STATUS;
   logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC;
   logic [NUM_LANES-1:0] PAUSE_BUSY;
   logic [NUM_LANES-1:0] PAUSE_DONE;
   logic [NUM_LANES-1:0] PAUSE_OVERRUN;

   modport master (
      output HS_IO_CLK_PAUSE,
      output LANE_EN,
      output CLR_STATUS,
      input  HS_IO_CLK_PAUSE_SYNC,
      input  PAUSE_BUSY,
      input  PAUSE_DONE,
      input  PAUSE_OVERRUN
   );

   modport slave (
      input  HS_IO_CLK_PAUSE,
      input  LANE_EN,
      input  CLR_STATUS,
      output HS_IO_CLK_PAUSE_SYNC,
      output PAUSE_BUSY,
      output PAUSE_DONE,
      output PAUSE_OVERRUN
   );
endinterface

// File: rtl/lanectrl_pause_sync_mc.sv
// Multi-lane HS_IO clock-pause synchroniser. Each lane synchronises an
// asynchronous pause request, then a small FSM stretches it to a minimum
// width, follows the request while it stays high, and inserts a guard gap
// before the next pause may start. Busy/done/overrun status per lane.
module lanectrl_pause_sync_mc #(
   parameter int NUM_LANES        = 4,
   parameter int SYNC_STAGES      = 2,
   parameter int MIN_PAUSE_CYCLES = 2,
   parameter int GUARD_CYCLES     = 1,
   parameter int FALL_EDGE_OUT    = 0
) (
   input logic                    CLK,
   input logic                    RESET,
   lanectrl_pause_sync_mc_if.slave bus
);

   localparam int CNT_MAX  = (MIN_PAUSE_CYCLES > GUARD_CYCLES) ? MIN_PAUSE_CYCLES : GUARD_CYCLES;
   localparam int CNT_BITS = $clog2(CNT_MAX + 1);
   localparam int CNT_W    = (CNT_BITS > 4) ? CNT_BITS : 4;
   localparam logic [CNT_W-1:0] MIN_LOAD   = CNT_W'(MIN_PAUSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

   // Out-of-range parameters instantiate a module that does not exist, so
   // elaboration stops with a clear pointer to the offending instance.
   if (NUM_LANES < 1 || NUM_LANES > 16 ||
       SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
       MIN_PAUSE_CYCLES < 1 ||
       GUARD_CYCLES < 0 || GUARD_CYCLES > 15 ||
       (FALL_EDGE_OUT != 0 && FALL_EDGE_OUT != 1)) begin : g_bad_params
      lanectrl_pause_sync_mc_illegal_parameter u_trap ();
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2,
      ST_GUARD  = 2'd3
   } state_t;

   logic [NUM_LANES-1:0] pause_sync_v;
   logic [NUM_LANES-1:0] busy_v;
   logic [NUM_LANES-1:0] done_v;
   logic [NUM_LANES-1:0] overrun_v;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [SYNC_STAGES-1:0] sync_pipe;
      logic                   s;
      logic                   s_d;
      logic                   s_rise;
      state_t                 state;
      logic [CNT_W-1:0]       cnt;
      logic                   pause_q;
      logic                   busy_q;
      logic                   done_q;
      logic                   overrun_q;
      logic                   leave_pause;

      assign s      = sync_pipe[SYNC_STAGES-1];
      assign s_rise = s & ~s_d;

      // The pause ends once the minimum width has elapsed and the request has dropped.
      assign leave_pause = ((state == ST_ASSERT) && (cnt == '0) && !s) ||
                           ((state == ST_HOLD) && !s);

      // Synchroniser chain plus previous-value flop for edge detection.
      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            sync_pipe <= '0;
            s_d       <= 1'b0;
         end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], bus.HS_IO_CLK_PAUSE[l]};
            s_d       <= s;
         end
      end

      // Pause FSM with registered pause/busy/done outputs.
      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pause_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            done_q <= 1'b0;
            unique case (state)
               ST_IDLE: begin
                  if (s && bus.LANE_EN[l]) begin
                     state   <= ST_ASSERT;
                     cnt     <= MIN_LOAD;
                     pause_q <= 1'b1;
                     busy_q  <= 1'b1;
                  end
               end
               ST_ASSERT: begin
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else if (s) begin
                     state <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  state <= ST_HOLD;
               end
               ST_GUARD: begin
                  if (cnt == '0) begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  pause_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
            // Exit from ASSERT/HOLD overrides the per-state updates above.
            if (leave_pause) begin
               pause_q <= 1'b0;
               done_q  <= 1'b1;
               if (GUARD_CYCLES > 0) begin
                  state <= ST_GUARD;
                  cnt   <= GUARD_LOAD;
               end else begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
         end
      end

      // Sticky overrun: a new request edge during GUARD; a set beats a clear.
      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            overrun_q <= 1'b0;
         end else if ((state == ST_GUARD) && s_rise) begin
            overrun_q <= 1'b1;
         end else if (bus.CLR_STATUS) begin
            overrun_q <= 1'b0;
         end
      end

      if (FALL_EDGE_OUT != 0) begin : g_fall
         logic pause_n;

         // Retime the pause output on the falling edge for half a cycle of extra margin.
         always_ff @(negedge CLK or posedge RESET) begin
            if (RESET) begin
               pause_n <= 1'b0;
            end else begin
               pause_n <= pause_q;
            end
         end

         assign pause_sync_v[l] = pause_n;
      end else begin : g_rise
         assign pause_sync_v[l] = pause_q;
      end

      assign busy_v[l]    = busy_q;
      assign done_v[l]    = done_q;
      assign overrun_v[l] = overrun_q;
   end

   assign bus.HS_IO_CLK_PAUSE_SYNC = pause_sync_v;
   assign bus.PAUSE_BUSY           = busy_v;
   assign bus.PAUSE_DONE           = done_v;
   assign bus.PAUSE_OVERRUN        = overrun_v;

endmodule
